fetch_queue: RTL and testbench

- Parametrised successor to the single-group fetch buffer: a circular multi-entry instruction queue between inst_fetch and decode.
- Accepts up to IN_WIDTH fetched instructions per cycle and presents up to OUT_WIDTH oldest instructions to decode.
- Decode may consume a variable number per cycle; pipeline flush on exception or branch redirect.

---
 rtl/ria_pkg.sv | 18 +
 rtl/fetch_queue_valid_count.sv | 20 ++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ria_pkg.sv
// Shared fetch/decode types and widths.
// Holds the fetch-buffer entry type and the front-end size constants.
`ifndef RIA_PKG_WIDTHS
`define RIA_PKG_WIDTHS
`define FECTH_WIDTH 4
`define DECODE_WIDTH 4
`endif

package ria_pkg;

    localparam int FQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

endpackage

// File: rtl/fetch_queue_valid_count.sv
// Popcount of a mask whose set bits are contiguous from bit 0.
// The count is one past the highest set bit.
module valid_count #(
    parameter int W = 4
) (
    input  logic [W-1:0]           i_mask,
    output logic [$clog2(W+1)-1:0] o_count
);

    localparam int CW = $clog2(W + 1);

    // highest set bit position + 1
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            if (i_mask[i]) o_count = CW'(i + 1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular multi-entry instruction queue between inst_fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to forward fetch slots straight to decode when empty.
module fetch_queue
    import ria_pkg::*;
#(
    parameter int IN_WIDTH  = `FECTH_WIDTH,
    parameter int OUT_WIDTH = `DECODE_WIDTH,
    parameter int DEPTH     = FQ_DEPTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  fb_entry_t [IN_WIDTH-1:0]       insts_in,
    input  logic [IN_WIDTH-1:0]            insts_in_valid,
    output fb_entry_t [OUT_WIDTH-1:0]      insts_out,
    output logic [OUT_WIDTH-1:0]           insts_out_valid,
    input  logic [$clog2(OUT_WIDTH+1)-1:0] deq_num,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(IN_WIDTH + 1);
    localparam int OW = $clog2(OUT_WIDTH + 1);

    fb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [IW-1:0]     w_n_in;
    logic [OW-1:0]     w_out_cnt;
    logic [OW-1:0]     w_pop;
    logic [IW-1:0]     w_skip;
    logic [CW-1:0]     w_enq;
    logic [OW-1:0]     w_hadv;
    logic [CW-1:0]     w_free;
    logic              w_wr_en;
    logic              w_byp;
    logic [IN_WIDTH-1:0] w_in_inc;

    valid_count #(.W(IN_WIDTH)) u_in_cnt (
        .i_mask  (insts_in_valid),
        .o_count (w_n_in)
    );

    valid_count #(.W(OUT_WIDTH)) u_out_cnt (
        .i_mask  (insts_out_valid),
        .o_count (w_out_cnt)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int MINW = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    assign w_byp = (r_count == '0) && !flush;
`else
    assign w_byp = 1'b0;
`endif

    // stall depends only on registered occupancy
    assign w_free  = CW'(DEPTH) - r_count;
    assign full    = w_free < CW'(IN_WIDTH);
    assign count   = r_count;
    assign w_wr_en = !full && !flush;

    // decode never pops more than is presented
    assign w_pop  = (deq_num < w_out_cnt) ? deq_num : w_out_cnt;
    // forwarded slots consumed this cycle are never stored
    assign w_skip = w_byp ? IW'(w_pop) : '0;
    assign w_enq  = w_wr_en ? (CW'(w_n_in) - CW'(w_skip)) : '0;
    assign w_hadv = w_byp ? '0 : w_pop;

    // oldest entries to decode; invalid slots read as zero
    always_comb begin
        insts_out       = '0;
        insts_out_valid = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            insts_out_valid[i] = CW'(i) < r_count;
            if (insts_out_valid[i]) insts_out[i] = r_mem[r_head + PW'(i)];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (w_byp) begin
            for (int i = 0; i < MINW; i++) begin
                insts_out_valid[i] = insts_in_valid[i];
                if (insts_in_valid[i]) insts_out[i] = insts_in[i];
            end
        end
`endif
    end

    // pointer and occupancy update; flush wins over enqueue and dequeue
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_hadv);
            r_tail  <= r_tail + PW'(w_enq);
            r_count <= r_count + w_enq - CW'(w_hadv);
        end
    end

    // storage write of the accepted, unforwarded slots starting at tail
    always_ff @(posedge clock) begin
        for (int j = 0; j < IN_WIDTH; j++) begin
            if (w_wr_en && IW'(j) >= w_skip && IW'(j) < w_n_in)
                r_mem[r_tail + PW'(j) - PW'(w_skip)] <= insts_in[j];
        end
    end

    assign w_in_inc = insts_in_valid + IN_WIDTH'(1);

    // fetch valids must be contiguous from slot 0
    assert property (@(posedge clock) disable iff (!reset)
        (insts_in_valid & w_in_inc) == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (default build, no bypass).
// Stimulus pushes accepted entries; a monitor pops them as decode consumes.
module tb_fetch_queue;
    import ria_pkg::*;

    logic            clock;
    logic            reset;
    logic            flush;
    fb_entry_t [3:0] insts_in;
    logic [3:0]      insts_in_valid;
    fb_entry_t [3:0] insts_out;
    logic [3:0]      insts_out_valid;
    logic [2:0]      deq_num;
    logic            full;
    logic [4:0]      count;

    fetch_queue dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .insts_in        (insts_in),
        .insts_in_valid  (insts_in_valid),
        .insts_out       (insts_out),
        .insts_out_valid (insts_out_valid),
        .deq_num         (deq_num),
        .full            (full),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    fb_entry_t exp_q [$];
    int        mcnt;
    int        n_cmp;
    int        n_bad;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // monitor: state checks plus in-order compare of consumed entries
    always @(posedge clock) begin
        if (reset) begin
            logic [3:0] emask;
            int npop;
            fb_entry_t e;
            emask = (mcnt >= 4) ? 4'hF : 4'((1 << mcnt) - 1);
            chk("count", 64'(count), 64'(mcnt));
            chk("full", 64'(full), 64'((16 - mcnt) < 4));
            chk("out_valid", 64'(insts_out_valid), 64'(emask));
            if (mcnt == 0) chk("out_zero", 64'(insts_out), 64'd0);
            if (!flush) begin
                npop = $countones(insts_out_valid);
                if (int'(deq_num) < npop) npop = int'(deq_num);
                for (int k = 0; k < npop; k++) begin
                    if (exp_q.size() == 0) begin
                        chk("underflow", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("entry", insts_out[k], e);
                    end
                end
            end
        end
    end

    // one cycle: drive at negedge, model update just after posedge
    task automatic step(input int nv, input logic [31:0] pc0,
                        input int deq, input bit fl);
        bit acc;
        int pop;
        for (int k = 0; k < 4; k++) begin
            insts_in[k].pc   = pc0 + 32'(4 * k);
            insts_in[k].inst = 32'hC0DE_0000 ^ (pc0 + 32'(4 * k));
        end
        insts_in_valid = 4'((1 << nv) - 1);
        deq_num = 3'(deq);
        flush = fl;
        acc = !fl && (16 - mcnt >= 4) && nv > 0;
        if (acc)
            for (int k = 0; k < nv; k++) exp_q.push_back(insts_in[k]);
        @(posedge clock);
        #1;
        pop = (mcnt < 4) ? mcnt : 4;
        if (deq < pop) pop = deq;
        if (fl) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            mcnt = mcnt + (acc ? nv : 0) - pop;
        end
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mcnt = 0;
        reset = 1'b0;
        flush = 1'b0;
        insts_in = '0;
        insts_in_valid = '0;
        deq_num = '0;
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_valid", 64'(insts_out_valid), 64'd0);
        chk("rst_out", 64'(insts_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // fill to 16, then a dropped fifth group
        step(4, 32'h00, 0, 0);
        step(4, 32'h10, 0, 0);
        step(4, 32'h20, 0, 0);
        step(4, 32'h30, 0, 0);
        step(4, 32'h40, 0, 0);
        // full with pop: rejected, then accepted
        step(4, 32'h40, 4, 0);
        step(4, 32'h40, 0, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 0, 1);

        // wrap: prefill 14, drain 12, write 4 into 14,15,0,1
        step(4, 32'h100, 0, 0);
        step(4, 32'h110, 0, 0);
        step(4, 32'h120, 0, 0);
        step(2, 32'h130, 0, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);
        step(4, 32'h200, 0, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 4, 0);

        // over-request: count 3, deq 4
        step(3, 32'h300, 0, 0);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 0, 0);

        // flush with a same-cycle write at count 10
        step(4, 32'h400, 0, 0);
        step(4, 32'h410, 0, 0);
        step(2, 32'h420, 0, 0);
        step(4, 32'h500, 2, 1);
        step(0, 32'h0, 0, 0);

        // async reset mid-operation at count 7
        step(4, 32'h600, 0, 0);
        step(3, 32'h610, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(insts_out_valid), 64'd0);
        chk("arst_full", 64'(full), 64'd0);
        mcnt = 0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        step(2, 32'h700, 0, 0);
        chk("post_rst_valid", 64'(insts_out_valid), 64'h3);
        step(0, 32'h0, 4, 0);
        step(0, 32'h0, 0, 0);
        chk("leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
